// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle IF/ID/EX/MEM/WB sequencer for the 16-bit TSC datapath; owns num_inst and is_halted.
// Optional MEM_HANDSHAKE_EN: memory accesses end on mem_ready instead of a fixed MEM_LATENCY count.
module multicycle_ctrl_fsm #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] inst,
  input  logic        bcond,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  pc_src,
  output logic        reg_write,
  output logic [1:0]  wr_reg_ctrl,
  output logic [1:0]  wr_data_ctrl,
  output logic        wwd_en,
  output logic        inst_done,
  output logic [15:0] num_inst,
  output logic        is_halted
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  state_t state, next_state;
  logic   acc_done;

  logic [3:0] opcode;
  logic [5:0] func;
  logic       is_branch, is_ialu, is_lwd, is_swd, is_jmp, is_jal;
  logic       is_ralu, is_jpr, is_jrl, is_wwd, is_hlt;
  logic [5:0] unused_bits;

  assign opcode    = inst[15:12];
  assign func      = inst[5:0];
  assign is_branch = (opcode <= 4'd3);
  assign is_ialu   = (opcode >= 4'd4) && (opcode <= 4'd6);
  assign is_lwd    = (opcode == 4'd7);
  assign is_swd    = (opcode == 4'd8);
  assign is_jmp    = (opcode == 4'd9);
  assign is_jal    = (opcode == 4'd10);
  assign is_ralu   = (opcode == 4'd15) && (func <= 6'd7);
  assign is_jpr    = (opcode == 4'd15) && (func == 6'd25);
  assign is_jrl    = (opcode == 4'd15) && (func == 6'd26);
  assign is_wwd    = (opcode == 4'd15) && (func == 6'd28);
  assign is_hlt    = (opcode == 4'd15) && (func == 6'd29);
  assign unused_bits = inst[11:6];

`ifdef MEM_HANDSHAKE_EN
  assign acc_done = mem_ready;
`else
  localparam logic [3:0] LAT_LAST = 4'(MEM_LATENCY - 1);
  logic [3:0] wait_cnt;
  logic       unused_ready;

  assign unused_ready = mem_ready;
  assign acc_done     = (wait_cnt == LAT_LAST);

  // Counter runs only inside an access and is back at zero whenever IF/MEM is left.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= 4'd0;
    end else if ((state == S_IF || state == S_MEM) && !acc_done) begin
      wait_cnt <= wait_cnt + 4'd1;
    end else begin
      wait_cnt <= 4'd0;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IF;
      num_inst <= 16'd0;
    end else begin
      state <= next_state;
      if (inst_done) num_inst <= num_inst + 16'd1;
    end
  end

  always_comb begin
    next_state   = state;
    pc_write     = 1'b0;
    ir_write     = 1'b0;
    iord         = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'd0;
    pc_src       = 2'd0;
    reg_write    = 1'b0;
    wr_reg_ctrl  = 2'd0;
    wr_data_ctrl = 2'd0;
    wwd_en       = 1'b0;
    inst_done    = 1'b0;
    case (state)
      S_IF: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        if (acc_done) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = S_ID;
        end
      end
      S_ID: begin
        alu_src_b = 2'd2;
        if (is_jmp || is_jal) begin
          pc_src   = 2'd2;
          pc_write = 1'b1;
        end
        if (is_jpr || is_jrl) begin
          pc_src   = 2'd3;
          pc_write = 1'b1;
        end
        // Link writes store the already-incremented PC into $2.
        if (is_jal || is_jrl) begin
          reg_write    = 1'b1;
          wr_reg_ctrl  = 2'd2;
          wr_data_ctrl = 2'd2;
        end
        wwd_en = is_wwd;
        if (is_branch || is_ialu || is_lwd || is_swd || is_ralu) begin
          next_state = S_EX;
        end else begin
          inst_done  = 1'b1;
          next_state = is_hlt ? S_HALT : S_IF;
        end
      end
      S_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = (is_ralu || is_branch) ? 2'd0 : 2'd2;
        if (is_branch) begin
          pc_src     = 2'd1;
          pc_write   = bcond;
          inst_done  = 1'b1;
          next_state = S_IF;
        end else if (is_lwd || is_swd) begin
          next_state = S_MEM;
        end else begin
          next_state = S_WB;
        end
      end
      S_MEM: begin
        iord      = 1'b1;
        mem_read  = is_lwd;
        mem_write = is_swd;
        if (acc_done) begin
          inst_done  = is_swd;
          next_state = is_swd ? S_IF : S_WB;
        end
      end
      S_WB: begin
        reg_write    = 1'b1;
        wr_reg_ctrl  = is_ralu ? 2'd1 : 2'd0;
        wr_data_ctrl = is_lwd ? 2'd1 : 2'd0;
        inst_done    = 1'b1;
        next_state   = S_IF;
      end
      S_HALT: next_state = S_HALT;
      default: next_state = S_IF;
    endcase
    // Nothing may strobe while reset is asserted, even mid-access.
    if (!reset_n) begin
      pc_write     = 1'b0;
      ir_write     = 1'b0;
      iord         = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      alu_src_a    = 1'b0;
      alu_src_b    = 2'd0;
      pc_src       = 2'd0;
      reg_write    = 1'b0;
      wr_reg_ctrl  = 2'd0;
      wr_data_ctrl = 2'd0;
      wwd_en       = 1'b0;
      inst_done    = 1'b0;
    end
  end

  assign is_halted = (state == S_HALT);

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm (default build): a 1-cycle-memory instance runs the
// instruction mix, a MEM_LATENCY=4 instance shares its stimulus to exercise the wait counter.
module tb_multicycle_ctrl_fsm;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] inst;
  logic        bcond;
  logic        mem_ready;

  logic        pc_write, ir_write, iord, mem_read, mem_write, alu_src_a;
  logic [1:0]  alu_src_b, pc_src, wr_reg_ctrl, wr_data_ctrl;
  logic        reg_write, wwd_en, inst_done, is_halted;
  logic [15:0] num_inst;

  logic        s_pc_write, s_ir_write, s_iord, s_mem_read, s_mem_write, s_alu_src_a;
  logic [1:0]  s_alu_src_b, s_pc_src, s_wr_reg_ctrl, s_wr_data_ctrl;
  logic        s_reg_write, s_wwd_en, s_inst_done, s_is_halted;
  logic [15:0] s_num_inst;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.MEM_LATENCY(1)) dut (
    .clk(clk), .reset_n(reset_n), .inst(inst), .bcond(bcond), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .reg_write(reg_write), .wr_reg_ctrl(wr_reg_ctrl), .wr_data_ctrl(wr_data_ctrl),
    .wwd_en(wwd_en), .inst_done(inst_done), .num_inst(num_inst), .is_halted(is_halted)
  );

  multicycle_ctrl_fsm #(.MEM_LATENCY(4)) dut_slow (
    .clk(clk), .reset_n(reset_n), .inst(inst), .bcond(bcond), .mem_ready(mem_ready),
    .pc_write(s_pc_write), .ir_write(s_ir_write), .iord(s_iord), .mem_read(s_mem_read),
    .mem_write(s_mem_write), .alu_src_a(s_alu_src_a), .alu_src_b(s_alu_src_b),
    .pc_src(s_pc_src), .reg_write(s_reg_write), .wr_reg_ctrl(s_wr_reg_ctrl),
    .wr_data_ctrl(s_wr_data_ctrl), .wwd_en(s_wwd_en), .inst_done(s_inst_done),
    .num_inst(s_num_inst), .is_halted(s_is_halted)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Starts in an IF cycle, counts cycles up to and including inst_done, ends in the next IF.
  task automatic run_count(input string tag, input logic [15:0] i, input int exp_n);
    int n;
    logic clash;
    inst  = i;
    #1;
    n     = 1;
    clash = mem_read & mem_write;
    while (!inst_done && n < 30) begin
      tick();
      n++;
      clash = clash | (mem_read & mem_write);
    end
    check({tag, "_cycles"}, 16'(n), 16'(exp_n));
    check({tag, "_rd_wr_clash"}, {15'd0, clash}, 16'd0);
    tick();
  endtask

  initial begin
    reset_n   = 1'b0;
    inst      = 16'hF1C0;
    bcond     = 1'b0;
    mem_ready = 1'b0;
    repeat (3) tick();
    check("rst_mem_read", {15'd0, mem_read}, 16'd0);
    check("rst_ir_write", {15'd0, ir_write}, 16'd0);
    check("rst_num_inst", num_inst, 16'd0);
    check("rst_is_halted", {15'd0, is_halted}, 16'd0);

    // ADD $3,$1,$2
    reset_n = 1'b1;
    #1;
    check("add_if_mem_read", {15'd0, mem_read}, 16'd1);
    check("add_if_iord", {15'd0, iord}, 16'd0);
    check("add_if_ir_write", {15'd0, ir_write}, 16'd1);
    check("add_if_pc_write", {15'd0, pc_write}, 16'd1);
    check("add_if_alu_src_b", {14'd0, alu_src_b}, 16'd1);
    check("slow_if1_ir_write", {15'd0, s_ir_write}, 16'd0);
    tick();
    check("add_id_alu_src_b", {14'd0, alu_src_b}, 16'd2);
    check("add_id_pc_write", {15'd0, pc_write}, 16'd0);
    check("add_id_inst_done", {15'd0, inst_done}, 16'd0);
    check("slow_if2_ir_write", {15'd0, s_ir_write}, 16'd0);
    tick();
    check("add_ex_alu_src_a", {15'd0, alu_src_a}, 16'd1);
    check("add_ex_alu_src_b", {14'd0, alu_src_b}, 16'd0);
    check("slow_if3_ir_write", {15'd0, s_ir_write}, 16'd0);
    check("slow_if3_mem_read", {15'd0, s_mem_read}, 16'd1);
    tick();
    check("add_wb_reg_write", {15'd0, reg_write}, 16'd1);
    check("add_wb_wr_reg_ctrl", {14'd0, wr_reg_ctrl}, 16'd1);
    check("add_wb_wr_data_ctrl", {14'd0, wr_data_ctrl}, 16'd0);
    check("add_wb_inst_done", {15'd0, inst_done}, 16'd1);
    check("add_wb_num_inst", num_inst, 16'd0);
    check("slow_if4_ir_write", {15'd0, s_ir_write}, 16'd1);
    check("slow_if4_mem_read", {15'd0, s_mem_read}, 16'd1);
    tick();
    check("add_num_inst", num_inst, 16'd1);

    // LWD
    inst = 16'h7106;
    tick();
    tick();
    check("lwd_ex_alu_src_b", {14'd0, alu_src_b}, 16'd2);
    tick();
    check("lwd_mem_iord", {15'd0, iord}, 16'd1);
    check("lwd_mem_read", {15'd0, mem_read}, 16'd1);
    check("lwd_mem_write", {15'd0, mem_write}, 16'd0);
    check("lwd_mem_pc_write", {15'd0, pc_write}, 16'd0);
    check("lwd_mem_inst_done", {15'd0, inst_done}, 16'd0);
    tick();
    check("lwd_wb_reg_write", {15'd0, reg_write}, 16'd1);
    check("lwd_wb_wr_data_ctrl", {14'd0, wr_data_ctrl}, 16'd1);
    check("lwd_wb_wr_reg_ctrl", {14'd0, wr_reg_ctrl}, 16'd0);
    check("lwd_wb_inst_done", {15'd0, inst_done}, 16'd1);
    tick();

    // SWD
    inst = 16'h8106;
    tick();
    tick();
    tick();
    check("swd_mem_write", {15'd0, mem_write}, 16'd1);
    check("swd_mem_read", {15'd0, mem_read}, 16'd0);
    check("swd_mem_iord", {15'd0, iord}, 16'd1);
    check("swd_mem_inst_done", {15'd0, inst_done}, 16'd1);
    tick();

    // BEQ not taken, then taken
    for (int b = 0; b < 2; b++) begin
      inst  = 16'h1106;
      bcond = b[0];
      tick();
      tick();
      check("beq_ex_pc_write", {15'd0, pc_write}, {15'd0, b[0]});
      check("beq_ex_pc_src", {14'd0, pc_src}, 16'd1);
      check("beq_ex_inst_done", {15'd0, inst_done}, 16'd1);
      tick();
    end
    bcond = 1'b0;

    // JAL, WWD
    inst = 16'hA005;
    tick();
    check("jal_id_pc_src", {14'd0, pc_src}, 16'd2);
    check("jal_id_pc_write", {15'd0, pc_write}, 16'd1);
    check("jal_id_reg_write", {15'd0, reg_write}, 16'd1);
    check("jal_id_wr_reg_ctrl", {14'd0, wr_reg_ctrl}, 16'd2);
    check("jal_id_wr_data_ctrl", {14'd0, wr_data_ctrl}, 16'd2);
    check("jal_id_inst_done", {15'd0, inst_done}, 16'd1);
    tick();
    inst = 16'hF01C;
    tick();
    check("wwd_id_wwd_en", {15'd0, wwd_en}, 16'd1);
    check("wwd_id_pc_write", {15'd0, pc_write}, 16'd0);
    tick();
    check("wwd_if_wwd_en", {15'd0, wwd_en}, 16'd0);

    run_count("jpr", 16'hF019, 2);
    run_count("nop", 16'hB000, 2);
    run_count("jrl", 16'hF01A, 2);
    run_count("ori", 16'h5106, 4);
    check("num_inst_11", num_inst, 16'd11);

    // HLT
    inst = 16'hF01D;
    tick();
    check("hlt_id_inst_done", {15'd0, inst_done}, 16'd1);
    tick();
    check("hlt_is_halted", {15'd0, is_halted}, 16'd1);
    check("hlt_mem_read", {15'd0, mem_read}, 16'd0);
    check("hlt_num_inst", num_inst, 16'd12);
    tick();
    tick();
    check("hlt_hold_is_halted", {15'd0, is_halted}, 16'd1);
    check("hlt_hold_pc_write", {15'd0, pc_write}, 16'd0);
    check("hlt_hold_num_inst", num_inst, 16'd12);

    // Reset out of HALT, then reset in the middle of a load's MEM cycle
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
    check("rehalt_is_halted", {15'd0, is_halted}, 16'd0);
    check("rehalt_num_inst", num_inst, 16'd0);
    inst = 16'h7106;
    tick();
    tick();
    tick();
    check("mid_mem_read_pre", {15'd0, mem_read}, 16'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_mem_read", {15'd0, mem_read}, 16'd0);
    check("mid_rst_iord", {15'd0, iord}, 16'd0);
    check("mid_rst_reg_write", {15'd0, reg_write}, 16'd0);
    tick();
    reset_n = 1'b1;
    #1;
    check("mid_rst_if_mem_read", {15'd0, mem_read}, 16'd1);
    check("mid_rst_if_iord", {15'd0, iord}, 16'd0);
    check("mid_rst_if_ir_write", {15'd0, ir_write}, 16'd1);
    check("mid_rst_num_inst", num_inst, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
